// File: rtl/addr_add_arbiter.sv
// Round-robin share of one 32-bit adder among NUM_REQ requesters; 1-cycle registered tagged response.
// A held response (rsp_valid && !rsp_ready) blocks all grants; consume and reload happen on the same edge.
module adder32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  assign sum = a + b;
endmodule

module addr_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_sum,
  output logic [ID_W-1:0]       rsp_id
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt;
  logic [PTR_W-1:0] ptr_nxt;
  logic             can_accept;
  logic             any_vld;
  logic             xfer;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [31:0]      sum;

  // Scan from the pointer upward, wrapping; the first valid requester wins.
  always_comb begin
    int               idx;
    logic             found;
    logic [PTR_W-1:0] idx_w;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(ptr) + k) % NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!found && req_valid[idx_w]) begin
        found = 1'b1;
        gnt   = idx_w;
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign any_vld    = |req_valid;

  // rst_n gates req_ready so nothing is accepted while the response register is held in reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && can_accept && any_vld && (gnt == PTR_W'(i));
    end
  end

  assign xfer    = |req_ready;
  assign op_a    = req_a[32*gnt +: 32];
  assign op_b    = req_b[32*gnt +: 32];
  assign ptr_nxt = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;

  adder32b u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum;
      rsp_id    <= ID_W'(gnt);
      ptr       <= ptr_nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_addr_add_arbiter.sv
// Directed bench for addr_add_arbiter with a cycle-level reference model and literal spot checks.
module tb_addr_add_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_sum;
  logic [IW-1:0]   rsp_id;

  int checks = 0;
  int errors = 0;

  // Reference model state: the response register and the round-robin pointer.
  logic        m_vld;
  logic [31:0] m_sum;
  int          m_id;
  int          m_ptr;

  always #5 clk = ~clk;

  addr_add_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester that must win given the model pointer, or -1 if none is valid.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      logic [1:0] ix;
      ix = 2'((m_ptr + k) % N);
      if (req_valid[ix]) return int'(ix);
    end
    return -1;
  endfunction

  function automatic logic [31:0] sum_of(input int g);
    logic [31:0] s;
    s = req_a[32*g +: 32] + req_b[32*g +: 32];
    return s;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    if (!rst_n) return '0;
    if (m_vld && !rsp_ready) return '0;
    if (pick() < 0) return '0;
    return N'(1) << pick();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      m_sum <= '0;
      m_id  <= 0;
      m_ptr <= 0;
    end else if ((!m_vld || rsp_ready) && pick() >= 0) begin
      m_vld <= 1'b1;
      m_sum <= sum_of(pick());
      m_id  <= pick();
      m_ptr <= (pick() + 1) % N;
    end else if (rsp_ready) begin
      m_vld <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("model_rsp_valid", 32'(rsp_valid), 32'(m_vld));
    chk("model_rsp_sum",   rsp_sum,        m_sum);
    chk("model_rsp_id",    32'(rsp_id),    32'(m_id));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    int exp_ids[6];
    exp_ids   = '{0, 1, 2, 3, 0, 1};
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    set_op(0, 32'h0000_1000, 32'h0000_0024);
    set_op(1, 32'hFFFF_FFF0, 32'h0000_0020);
    set_op(2, 32'h1234_5678, 32'h1111_1111);
    set_op(3, 32'h8000_0000, 32'h8000_0001);

    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_sum",   rsp_sum,        32'h0);
    chk("reset_rsp_id",    32'(rsp_id),    32'h0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    next();
    next();
    rst_n = 1'b1;

    // Single request on requester 0.
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    next();
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_sum",   rsp_sum,        32'h0000_1024);
    chk("t1_id",    32'(rsp_id),    32'h0);

    // Modulo-2^32 wrap on requester 1.
    req_valid = 4'b0010;
    #1 chk("t2_ready", 32'(req_ready), 32'h2);
    next();
    chk("t2_sum", rsp_sum,     32'h0000_0010);
    chk("t2_id",  32'(rsp_id), 32'h1);

    // Grant 2, then 1010 must go 3 before 1.
    req_valid = 4'b0100;
    #1 chk("t4_ready2", 32'(req_ready), 32'h4);
    next();
    chk("t4_sum2", rsp_sum,     32'h2345_6789);
    chk("t4_id2",  32'(rsp_id), 32'h2);
    req_valid = 4'b1010;
    #1 chk("t4_ready3", 32'(req_ready), 32'h8);
    next();
    chk("t4_id3",  32'(rsp_id), 32'h3);
    chk("t4_sum3", rsp_sum,     32'h0000_0001);
    req_valid = 4'b0010;
    #1 chk("t4_ready1", 32'(req_ready), 32'h2);
    next();
    chk("t4_id1", 32'(rsp_id), 32'h1);

    // Bring the pointer back to 0, then all four requesting.
    req_valid = 4'b1000;
    next();
    req_valid = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      #1 chk("t3_ready", 32'(req_ready), 32'(1) << exp_ids[j]);
      next();
      chk("t3_valid", 32'(rsp_valid), 32'h1);
      chk("t3_id",    32'(rsp_id),    32'(exp_ids[j]));
    end

    // Backpressure on a 0x1024 response from requester 0.
    req_valid = 4'b0001;
    next();
    chk("t5_sum0", rsp_sum, 32'h0000_1024);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1 chk("t5_ready_held", 32'(req_ready), 32'h0);
    for (int j = 0; j < 3; j++) begin
      next();
      chk("t5_valid_held", 32'(rsp_valid), 32'h1);
      chk("t5_sum_held",   rsp_sum,        32'h0000_1024);
      chk("t5_id_held",    32'(rsp_id),    32'h0);
      chk("t5_ready_zero", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    #1 chk("t5_ready_release", 32'(req_ready), 32'h2);
    next();
    chk("t5_valid_nobubble", 32'(rsp_valid), 32'h1);
    chk("t5_id_next",        32'(rsp_id),    32'h1);
    chk("t5_sum_next",       rsp_sum,        32'h0000_0010);

    // Asynchronous reset mid-cycle while a response is pending.
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("t6_async_valid", 32'(rsp_valid), 32'h0);
    chk("t6_async_ptr_ready", 32'(req_ready), 32'h0);
    next();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1 chk("t6_ready_after", 32'(req_ready), 32'h1);
    next();
    chk("t6_id_after",  32'(rsp_id), 32'h0);
    chk("t6_sum_after", rsp_sum,     32'h0000_1024);
    req_valid = '0;
    next();
    chk("t6_drained", 32'(rsp_valid), 32'h0);
    chk("t6_sum_kept", rsp_sum, 32'h0000_1024);
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/addr_add_arbiter.md
Name: addr_add_arbiter

Overview:
Shares one 32-bit address adder among NUM_REQ address-calculation requesters (e.g. load/store, branch target, fetch) using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake. The winner's modulo-2^32 sum is registered and returned on a single tagged response channel. The block contains an adder32b instance for the sum; it is the only consumer of that adder.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
ID_W, 2, response tag width; must be >= max(1, clog2(NUM_REQ))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_a  in  32*NUM_REQ  operand A, requester i at bits [32*i+31:32*i]
req_b  in  32*NUM_REQ  operand B, same packing
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_sum  out  32  registered sum
rsp_id  out  ID_W  index of the requester that produced rsp_sum

Behaviour:
- Reset (rst_n low, async): rsp_valid=0, rsp_sum=0, rsp_id=0, rr pointer=0. req_ready is all-zero while in reset.
- can_accept = !rsp_valid || rsp_ready (combinational).
- Grant selection (combinational): g = first i with req_valid[i], scanning from pointer upward with wrap to 0.
- req_ready[g]=1 only when can_accept and at least one req_valid is set. All other req_ready bits are 0.
- req_ready must not depend on req_valid of the non-winning requesters.
- Transfer occurs when req_valid[g] && req_ready[g]. On the next edge:
  - rsp_sum <= req_a[g] + req_b[g], modulo 2^32; carry discarded, no overflow flag.
  - rsp_id <= g; rsp_valid <= 1.
  - pointer <= (g+1) mod NUM_REQ.
- Latency: 1 cycle from transfer to rsp_valid. Throughput: 1 response per cycle while rsp_ready=1.
- Response held (rsp_valid=1, rsp_ready=0):
  - rsp_sum and rsp_id stay stable.
  - req_ready is all 0; pointer unchanged.
- Response consumed with no new transfer: rsp_valid <= 0. rsp_sum and rsp_id keep their last values.
- Simultaneous consume and new transfer: new response loaded in the same edge with no bubble.
- No requests valid: pointer unchanged.
- Requester protocol: once req_valid is asserted, it stays high with stable operands until accepted. The arbiter does not check this.
- Reset mid-operation: any pending response is discarded and the pointer returns to 0. The first grant after reset favours requester 0.
- NUM_REQ=1: pointer is constant 0 and rsp_id is always 0. The block degenerates to a one-stage registered adder with valid/ready.
- No combinational path from rsp_ready to rsp_valid, rsp_sum or rsp_id. The combinational path from rsp_ready to req_ready is permitted.

Test Plan:
1. Single request: req_valid=0001, a0=0x00001000, b0=0x00000024, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_sum=0x00001024, rsp_id=0.
2. Wrap-around: a1=0xFFFFFFF0, b1=0x00000020 on requester 1 -> rsp_sum=0x00000010, rsp_id=1.
3. Fairness: req_valid=1111 held, rsp_ready=1 -> consecutive rsp_id 0,1,2,3,0,1 with rsp_valid high every cycle after the first.
4. Pointer order: after a grant to requester 2, assert req_valid=1010 -> requester 3 is granted first, then requester 1.
5. Backpressure: rsp_valid=1 with rsp_sum=0x1024, rsp_ready=0 for 3 cycles while req_valid=1111 -> rsp_sum and rsp_id stable, req_ready=0000. Raise rsp_ready -> same cycle req_ready one-hot; next cycle new rsp_valid with no bubble.
6. Async reset: assert rst_n=0 mid-cycle while rsp_valid=1 -> rsp_valid=0 immediately without a clock edge. After release with req_valid=1111 -> first rsp_id=0.
